alu_sequencer: RTL and testbench

Upstream control stage for the combinational `alu`. It accepts one operation per valid/ready handshake and registers the operands and opcode that drive the ALU. It captures the 2N-bit ALU result, derives status flags, and holds the result until a downstream valid/ready handshake takes it. It also keeps an N-bit accumulator, so chained operations can reuse the previous result as operand a.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_flags.sv | 25 ++
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU sequencer and its helpers.
//   - Opcode encodings understood by the downstream combinational ALU.
//     Any code not listed below is executed by the ALU as OR.
//   - seq_state_t: the sequencer FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_flags.sv
// alu_flags: combinational status flags for a 2N-bit signed ALU result.
// Ports:
//   result  in   2N  ALU result
//   zero    out  1   result == 0
//   neg     out  1   sign bit of result
//   fit     out  1   result is representable as a signed N-bit value
module alu_flags #(
  parameter int N = 4
) (
  input  logic [2*N-1:0] result,
  output logic           zero,
  output logic           neg,
  output logic           fit
);

  // A value fits in N signed bits when everything from bit N-1 upward is a
  // copy of the sign bit: either all ones or all zeros.
  logic [N:0] upper;

  assign upper = result[2*N-1:N-1];
  assign zero  = (result == '0);
  assign neg   = result[2*N-1];
  assign fit   = (&upper) | ~(|upper);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: control stage in front of a combinational ALU.
// Accepts one command per in_valid/in_ready handshake, registers the ALU
// operands and opcode, captures the 2N-bit ALU result one cycle later along
// with its flags, and holds it until the out_valid/out_ready handshake.
// An N-bit accumulator holds the low half of the last result and can stand
// in for operand a on the next command.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready and out_valid depend only on the FSM state (and rst for
// in_ready), never on the partner's valid/ready, so there is no
// combinational path between the two sides.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          command handshake
//   in_a, in_b, in_opcode      command operands and opcode
//   in_acc                     use accumulator as operand a
//   alu_a, alu_b, alu_opcode   registered ALU inputs
//   alu_out                    ALU result (2N bits)
//   out_valid/out_ready        result handshake
//   out_result                 captured result
//   out_zero, out_neg, out_fit captured flags
//   acc                        accumulator
//   dbg_state                  current FSM state (seq_state_t encoding)
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [2:0]     in_opcode,
  input  logic           in_acc,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [2:0]     alu_opcode,
  input  logic [2*N-1:0] alu_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_result,
  output logic           out_zero,
  output logic           out_neg,
  output logic           out_fit,
  output logic [N-1:0]   acc,
  output logic [1:0]     dbg_state
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic flag_zero;
  logic flag_neg;
  logic flag_fit;
  logic accept;
  logic capture;

  // Flags come from the live ALU output so they land in the same edge as
  // out_result rather than one cycle behind it.
  alu_flags #(.N(N)) u_flags (
    .result (alu_out),
    .zero   (flag_zero),
    .neg    (flag_neg),
    .fit    (flag_fit)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = EXEC;
      EXEC:                   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // in_ready is masked by rst so no command appears accepted while reset
  // holds the FSM.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign accept    = (state_q == IDLE) && in_valid;
  assign capture   = (state_q == EXEC);
  assign dbg_state = state_q;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_fit    <= 1'b0;
      acc        <= '0;
    end else begin
      if (accept) begin
        alu_a      <= in_acc ? acc : in_a;
        alu_b      <= in_b;
        alu_opcode <= in_opcode;
      end
      if (capture) begin
        out_result <= alu_out;
        out_zero   <= flag_zero;
        out_neg    <= flag_neg;
        out_fit    <= flag_fit;
        // Silent truncation; out_fit tells the consumer whether it mattered.
        acc        <= alu_out[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a behavioural ALU at the level above it.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_a = '0;
  logic [N-1:0]   in_b = '0;
  logic [2:0]     in_opcode = '0;
  logic           in_acc = 1'b0;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [2:0]     alu_opcode;
  logic [2*N-1:0] alu_out;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] out_result;
  logic           out_zero;
  logic           out_neg;
  logic           out_fit;
  logic [N-1:0]   acc;
  logic [1:0]     dbg_state;

  alu_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .in_acc     (in_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_fit    (out_fit),
    .acc        (acc),
    .dbg_state  (dbg_state)
  );

  // Behavioural signed ALU: operands sign-extended to 2N bits.
  logic signed [2*N-1:0] sa;
  logic signed [2*N-1:0] sb;
  always_comb begin
    sa = {{N{alu_a[N-1]}}, alu_a};
    sb = {{N{alu_b[N-1]}}, alu_b};
    case (alu_opcode)
      OP_ADD:  alu_out = sa + sb;
      OP_SUB:  alu_out = sa - sb;
      OP_MUL:  alu_out = sa * sb;
      OP_AND:  alu_out = sa & sb;
      default: alu_out = sa | sb;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for in_ready at a falling edge, presents the command,
  // and leaves the DUT in DONE with out_ready low, sampled at a falling edge.
  task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic use_acc,
                         input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: in_ready stayed 0", tag);
    end
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_acc    = use_acc;
    @(posedge clk);               // accept edge t
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " exec out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);               // after edge t+1: DONE
    chk({tag, " done out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           use_acc;
    logic [N-1:0]   exp_alu_a;
    logic [2*N-1:0] exp_res;
    logic           exp_zero;
    logic           exp_neg;
    logic           exp_fit;
    logic [N-1:0]   exp_acc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Chained in order: acc carries from one row to the next.
    vecs[0]  = '{OP_ADD, 4'h3, 4'h4, 1'b0, 4'h3, 8'h07, 1'b0, 1'b0, 1'b1, 4'h7};
    vecs[1]  = '{OP_SUB, 4'h2, 4'h5, 1'b0, 4'h2, 8'hFD, 1'b0, 1'b1, 1'b1, 4'hD};
    vecs[2]  = '{OP_MUL, 4'h8, 4'h8, 1'b0, 4'h8, 8'h40, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{OP_ADD, 4'h3, 4'h4, 1'b0, 4'h3, 8'h07, 1'b0, 1'b0, 1'b1, 4'h7};
    vecs[4]  = '{OP_ADD, 4'hF, 4'h1, 1'b1, 4'h7, 8'h08, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[5]  = '{OP_SUB, 4'h2, 4'h8, 1'b1, 4'h8, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0};
    vecs[6]  = '{OP_AND, 4'hC, 4'h5, 1'b0, 4'hC, 8'h04, 1'b0, 1'b0, 1'b1, 4'h4};
    vecs[7]  = '{3'b111, 4'h1, 4'hE, 1'b0, 4'h1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'hF};
    vecs[8]  = '{OP_ADD, 4'h0, 4'h7, 1'b1, 4'hF, 8'h06, 1'b0, 1'b0, 1'b1, 4'h6};
    vecs[9]  = '{OP_MUL, 4'h7, 4'h7, 1'b0, 4'h7, 8'h31, 1'b0, 1'b0, 1'b0, 4'h1};
    vecs[10] = '{OP_MUL, 4'h7, 4'h8, 1'b0, 4'h7, 8'hC8, 1'b0, 1'b1, 1'b0, 4'h8};
  end

  // ---------------- test ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready",   32'(in_ready),   32'd0);
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst state",      32'(dbg_state),  32'(IDLE));
    chk("rst alu_a",      32'(alu_a),      32'd0);
    chk("rst alu_b",      32'(alu_b),      32'd0);
    chk("rst alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst out_result", 32'(out_result), 32'd0);
    chk("rst flags",      32'({out_zero, out_neg, out_fit}), 32'd0);
    chk("rst acc",        32'(acc),        32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Table-driven commands
    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc, tag);
      chk({tag, " alu_a"},      32'(alu_a),      32'(vecs[i].exp_alu_a));
      chk({tag, " alu_b"},      32'(alu_b),      32'(vecs[i].b));
      chk({tag, " alu_opcode"}, 32'(alu_opcode), 32'(vecs[i].op));
      chk({tag, " result"},     32'(out_result), 32'(vecs[i].exp_res));
      chk({tag, " zero"},       32'(out_zero),   32'(vecs[i].exp_zero));
      chk({tag, " neg"},        32'(out_neg),    32'(vecs[i].exp_neg));
      chk({tag, " fit"},        32'(out_fit),    32'(vecs[i].exp_fit));
      chk({tag, " acc"},        32'(acc),        32'(vecs[i].exp_acc));
      chk({tag, " in_ready"},   32'(in_ready),   32'd0);
      release_result();
      @(negedge clk);
      chk({tag, " back idle"},  32'(dbg_state),  32'(IDLE));
    end

    // Backpressure: held in DONE with a competing command on the input.
    run_cmd(OP_ADD, 4'h1, 4'h1, 1'b0, "bp");
    in_valid  = 1'b1;
    in_opcode = OP_ADD;
    in_a      = 4'h5;
    in_b      = 4'h5;
    in_acc    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp hold result",    32'(out_result), 32'h02);
      chk("bp hold flags",     32'({out_zero, out_neg, out_fit}), 32'b001);
      chk("bp hold out_valid", 32'(out_valid),  32'd1);
      chk("bp in_ready",       32'(in_ready),   32'd0);
      chk("bp alu_a kept",     32'(alu_a),      32'h1);
      chk("bp acc kept",       32'(acc),        32'h2);
    end
    out_ready = 1'b1;
    @(posedge clk);               // DONE -> IDLE, command not taken here
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release idle",     32'(dbg_state), 32'(IDLE));
    chk("bp release in_ready", 32'(in_ready),  32'd1);
    chk("bp not consumed",     32'(alu_a),     32'h1);
    @(posedge clk);               // now accepted
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp accepted state", 32'(dbg_state), 32'(EXEC));
    @(negedge clk);
    chk("bp second result", 32'(out_result), 32'h0A);
    chk("bp second valid",  32'(out_valid),  32'd1);
    release_result();

    // Reset during EXEC: no capture, everything cleared.
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = OP_ADD;
    in_a      = 4'h3;
    in_b      = 4'h2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rexec in exec", 32'(dbg_state), 32'(EXEC));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rexec state",      32'(dbg_state),  32'(IDLE));
    chk("rexec out_valid",  32'(out_valid),  32'd0);
    chk("rexec in_ready",   32'(in_ready),   32'd0);
    chk("rexec out_result", 32'(out_result), 32'd0);
    chk("rexec acc",        32'(acc),        32'd0);
    chk("rexec alu_a",      32'(alu_a),      32'd0);
    chk("rexec alu_b",      32'(alu_b),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rexec release ready", 32'(in_ready), 32'd1);

    // Reset together with out_ready in DONE.
    run_cmd(OP_SUB, 4'h2, 4'h5, 1'b0, "rdone");
    chk("rdone result", 32'(out_result), 32'hFD);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rdone state",      32'(dbg_state),  32'(IDLE));
    chk("rdone out_valid",  32'(out_valid),  32'd0);
    chk("rdone out_result", 32'(out_result), 32'd0);
    chk("rdone flags",      32'({out_zero, out_neg, out_fit}), 32'd0);
    chk("rdone acc",        32'(acc),        32'd0);
    chk("rdone alu_opcode", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdone release ready", 32'(in_ready), 32'd1);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
